// File: rtl/imm_decode_pkg.sv
// imm_decode_pkg: opcodes, format codes and the entry layout shared by the decode stage (IMMDEC_TARGET_EN adds a target field)
package imm_decode_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } imm_fmt_e;
endpackage

`ifdef IMMDEC_TARGET_EN
`define IMMDEC_ENTRY_T(W) struct packed {logic [W-1:0] imm; imm_decode_pkg::imm_fmt_e fmt; logic [W-1:0] pc; logic [W-1:0] tgt;}
`else
`define IMMDEC_ENTRY_T(W) struct packed {logic [W-1:0] imm; imm_decode_pkg::imm_fmt_e fmt; logic [W-1:0] pc;}
`endif

// File: rtl/imm_format_decode.sv
// imm_format_decode: combinational opcode-driven format select and immediate extension
module imm_format_decode
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);
    logic [6:0]  op;
    logic        s;
    logic        is_imm;
    logic        narrow;
    logic [31:0] v;
    always_comb begin
        op     = instr[6:0];
        s      = instr[31];
        is_imm = op == OP_IMM || (XLEN == 64 && op == OP_IMM_32);
        narrow = XLEN == 32 || op == OP_IMM_32;
        // funct3 001/101 share instr[13:12] == 01
        fmt = (op == OP_LOAD || op == OP_JALR) ? FMT_I :
              is_imm                           ? (instr[13:12] == 2'b01 ? FMT_SH : FMT_I) :
              op == OP_STORE                   ? FMT_S :
              op == OP_BRANCH                  ? FMT_B :
              (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
              op == OP_JAL                     ? FMT_J : FMT_NONE;
        v = fmt == FMT_I  ? {{20{s}}, instr[31:20]} :
            fmt == FMT_S  ? {{20{s}}, instr[31:25], instr[11:7]} :
            fmt == FMT_B  ? {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0} :
            fmt == FMT_U  ? {instr[31:12], 12'b0} :
            fmt == FMT_J  ? {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0} :
            fmt == FMT_SH ? {26'b0, narrow ? 1'b0 : instr[25], instr[24:20]} : '0;
        imm = XLEN'($signed(v));
    end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decoded-immediate pipeline stage behind an output/skid register pair (IMMDEC_TARGET_EN adds out_target)
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_e        out_fmt,
`ifdef IMMDEC_TARGET_EN
    output logic [XLEN-1:0] out_target,
`endif
    output logic [XLEN-1:0] out_pc
);
    typedef `IMMDEC_ENTRY_T(XLEN) entry_t;
    imm_fmt_e        dec_fmt;
    logic [XLEN-1:0] dec_imm;
    entry_t          in_e, o_d, o_q, k_d, k_q;
    logic            o_v_d, o_v_q, k_v_d, k_v_q, acc, adv;

    imm_format_decode #(.XLEN(XLEN)) u_dec (.instr(in_instr), .fmt(dec_fmt), .imm(dec_imm));

    always_comb begin
        in_e.imm = dec_imm;
        in_e.fmt = dec_fmt;
        in_e.pc  = in_pc;
`ifdef IMMDEC_TARGET_EN
        in_e.tgt = in_pc + dec_imm;
`endif
        acc   = in_valid && !k_v_q;
        adv   = !o_v_q || out_ready;
        // K can only hold an entry while O does, so it drains into O whenever O advances
        o_v_d = flush ? 1'b0 : adv ? (k_v_q || acc) : o_v_q;
        o_d   = adv ? (k_v_q ? k_q : acc ? in_e : o_q) : o_q;
        k_v_d = flush ? 1'b0 : adv ? 1'b0 : (k_v_q || acc);
        k_d   = (!adv && acc) ? in_e : k_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q   <= '0;
            k_q   <= '0;
            o_v_q <= 1'b0;
            k_v_q <= 1'b0;
        end else begin
            o_q   <= o_d;
            k_q   <= k_d;
            o_v_q <= o_v_d;
            k_v_q <= k_v_d;
        end
    end

    assign in_ready  = !k_v_q;
    assign out_valid = o_v_q;
    assign out_imm   = o_q.imm;
    assign out_fmt   = o_q.fmt;
    assign out_pc    = o_q.pc;
`ifdef IMMDEC_TARGET_EN
    assign out_target = o_q.tgt;
`endif
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: XLEN=32 and XLEN=64 stages in lockstep against a 2-deep FIFO reference model
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] imm32, pc32;
    logic [63:0] imm64, pc64;
    logic [2:0]  fmt32, fmt64;
`ifdef IMMDEC_TARGET_EN
    logic [31:0] tgt32;
    logic [63:0] tgt64;
`endif
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } txn_t;
    txn_t q[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32),
`ifdef IMMDEC_TARGET_EN
        .out_target(tgt32),
`endif
        .out_pc(pc32)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64),
`ifdef IMMDEC_TARGET_EN
        .out_target(tgt64),
`endif
        .out_pc(pc64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] ins, input int xl, output logic [2:0] f, output logic [63:0] imm);
        logic [6:0] op;
        logic [2:0] f3;
        longint     v;
        op = ins[6:0];
        f3 = ins[14:12];
        v  = 0;
        f  = 3'd0;
        case (op)
            7'h03, 7'h67: begin f = 3'd1; v = longint'($signed(ins[31:20])); end
            7'h13, 7'h1B: if (op == 7'h13 || xl == 64) begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    f = 3'd6;
                    v = (xl == 32 || op == 7'h1B) ? longint'(ins[24:20]) : longint'(ins[25:20]);
                end else begin
                    f = 3'd1;
                    v = longint'($signed(ins[31:20]));
                end
            end
            7'h23: begin f = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin f = 3'd3; v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
            7'h37, 7'h17: begin f = 3'd4; v = longint'($signed({ins[31:12], 12'b0})); end
            7'h6F: begin f = 3'd5; v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
            default: ;
        endcase
        imm = (xl == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    // compare both DUTs to the model mid-cycle, then advance the model across the next edge
    task automatic step();
        logic [2:0]  f;
        logic [63:0] im;
        txn_t        t;
        @(negedge clk);
        check("valid32", 64'(out_valid32), 64'(q.size() > 0));
        check("valid64", 64'(out_valid64), 64'(q.size() > 0));
        check("ready32", 64'(in_ready32), 64'(q.size() < 2));
        check("ready64", 64'(in_ready64), 64'(q.size() < 2));
        if (q.size() > 0) begin
            ref_dec(q[0].ins, 32, f, im);
            check("fmt32", 64'(fmt32), 64'(f));
            check("imm32", 64'(imm32), im);
            check("pc32", 64'(pc32), 64'(q[0].pc[31:0]));
`ifdef IMMDEC_TARGET_EN
            check("tgt32", 64'(tgt32), 64'(q[0].pc[31:0] + im[31:0]));
`endif
            ref_dec(q[0].ins, 64, f, im);
            check("fmt64", 64'(fmt64), 64'(f));
            check("imm64", imm64, im);
            check("pc64", pc64, q[0].pc);
`ifdef IMMDEC_TARGET_EN
            check("tgt64", tgt64, q[0].pc + im);
`endif
        end
        t.ins = in_instr;
        t.pc  = in_pc;
        if (flush) q.delete();
        else begin
            if (in_valid && q.size() < 2) begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                q.push_back(t);
            end else if (q.size() > 0 && out_ready) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    logic [6:0] ops [12];

    initial begin
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h13};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        #12;
        check("rst_valid", 64'(out_valid32), 64'd0);
        check("rst_ready", 64'(in_ready64), 64'd1);
        check("rst_imm", imm64, 64'd0);
        check("rst_fmt", 64'(fmt32), 64'd0);
        check("rst_pc", pc64, 64'd0);
`ifdef IMMDEC_TARGET_EN
        check("rst_tgt", tgt64, 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'hFFF00093, 64'h100); check("addi_fmt", 64'(fmt32), 64'd1); check("addi_imm", 64'(imm32), 64'hFFFFFFFF);
        send(32'hFE112E23, 64'h104); check("sw_fmt", 64'(fmt32), 64'd2); check("sw_imm", 64'(imm32), 64'hFFFFFFFC);
        send(32'hFE000CE3, 64'h108); check("beq_fmt", 64'(fmt32), 64'd3); check("beq_imm", 64'(imm32), 64'hFFFFFFF8);
        send(32'h123452B7, 64'h10C); check("lui_fmt", 64'(fmt32), 64'd4); check("lui_imm", 64'(imm32), 64'h12345000);
        send(32'h4030D093, 64'h110); check("srai_fmt", 64'(fmt32), 64'd6); check("srai_imm", 64'(imm32), 64'd3);
        send(32'h001000EF, 64'h1000); check("jal_imm", 64'(imm32), 64'h800);
`ifdef IMMDEC_TARGET_EN
        check("jal_tgt", 64'(tgt32), 64'h1800);
`endif
        send(32'h03F09093, 64'h200); check("slli64_imm", imm64, 64'd63); check("slli64_fmt", 64'(fmt64), 64'd6);
        send(32'h0010809B, 64'h204); check("addiw_imm", imm64, 64'd1); check("addiw32_fmt", 64'(fmt32), 64'd0);
        send(32'h0000007F, 64'h208); check("unk_fmt", 64'(fmt64), 64'd0); check("unk_imm", imm64, 64'd0);
        step();

        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h300; step();
        in_instr = 32'h00200093; in_pc = 64'h304; step();
        check("bp_full", 64'(in_ready32), 64'd0);
        in_instr = 32'h00300093; in_pc = 64'h308; step(); step();
        check("bp_hold", 64'(imm32), 64'd1);
        out_ready = 1'b1; step();
        check("bp_b", 64'(imm32), 64'd2);
        step();
        check("bp_c", 64'(imm32), 64'd3);
        in_valid = 1'b0; step();
        check("bp_empty", 64'(out_valid64), 64'd0);

        out_ready = 1'b0;
        send(32'h00500093, 64'h400); send(32'h00600093, 64'h404);
        in_valid = 1'b1; flush = 1'b1; in_instr = 32'h00700093; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid32), 64'd0);
        check("fl_ready", 64'(in_ready32), 64'd1);
        step();

        send(32'h00800093, 64'h500); send(32'h00900093, 64'h504);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid64), 64'd0);
        check("arst_ready", 64'(in_ready64), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h00A00093, 64'h600);
        check("post_rst_valid", 64'(out_valid32), 64'd1);
        check("post_rst_imm", 64'(imm32), 64'd10);

        for (int i = 0; i < 600; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 40) == 0;
            in_instr  = $urandom;
            in_instr[6:0] = ops[$urandom_range(0, 11)];
            in_pc     = {$urandom, $urandom};
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Pipelined immediate-decode stage: accepts raw RV32I/RV64I instruction words with their PC over a valid/ready handshake, decodes the instruction format directly from the opcode, and emits the sign-extended immediate, the format code and, optionally, the PC-relative target. It generalises the combinational immediate extender with an `XLEN` parameter, opcode-driven format selection and a registered output behind a two-entry skid buffer. It sits between fetch and the register-read/execute stage of the pipelined core.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `flush` in 1 — synchronous kill of all held entries.
- `in_valid` in 1 — instruction present.
- `in_ready` out 1 — stage can accept an instruction.
- `in_instr` in 32 — instruction word.
- `in_pc` in XLEN — PC of the instruction.
- `out_valid` out 1 — decoded entry present.
- `out_ready` in 1 — consumer accepts the entry.
- `out_imm` out XLEN — sign/zero-extended immediate.
- `out_fmt` out 3 — format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6.
- `out_pc` out XLEN — PC passed through.
- `out_target` out XLEN — `out_pc + out_imm`; present only with `IMMDEC_TARGET_EN`.

## Operation
- Format decode by opcode `in_instr[6:0]`:
  - LOAD 0000011, JALR 1100111: I.
  - OP_IMM 0010011: SH when funct3 is 001 or 101, otherwise I.
  - OP_IMM_32 0011011: same rule as OP_IMM, recognised only when XLEN=64.
  - STORE 0100011: S.
  - BRANCH 1100011: B.
  - LUI 0110111, AUIPC 0010111: U.
  - JAL 1101111: J.
  - Any other opcode: NONE.
- Immediates, all sign-extended from instr[31] to XLEN unless stated:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - SH: zero-extended shamt. The shamt is instr[24:20] when XLEN=32 or the opcode is OP_IMM_32; otherwise it is instr[25:20]. funct7 never reaches `out_imm`.
  - NONE: `out_imm` = 0.
- Storage: an output register (O) and a skid register (K), each holding {imm, fmt, pc} plus a valid bit.
- Accept = `in_valid && in_ready`.
- `in_ready` = !K.valid (combinational).
- Each cycle, in priority order:
  1. `flush`: O.valid and K.valid both clear. An accept in the same cycle is dropped.
  2. If O is empty, or `out_ready` is high, O loads from K when K is valid, otherwise from the accepted input. K then loads the input if both apply.
  3. Otherwise, when O is valid and `out_ready` is low, an accepted input goes into K.
- Ordering is strict FIFO; no entry is ever dropped or duplicated except on `flush`.

## Timing
- Latency: accept on edge N gives `out_valid` after edge N.
- Throughput: one entry per cycle while `out_ready` is held high.
- Reset values:
  - `out_valid` = 0.
  - `out_imm`, `out_fmt`, `out_pc`, `out_target` = 0.
  - K.valid = 0, so `in_ready` = 1 while in reset and after it.
- Full (O and K both valid): `in_ready` = 0. It returns to 1 the cycle after `out_ready` drains O.
- Empty with `in_valid` = 0: `out_valid` drops after the last handshake.
- `out_*` stays stable while `out_valid && !out_ready`.
- Reset asserted mid-stream discards both entries immediately, asynchronously.
- `out_target` arithmetic is modulo 2^XLEN; carry out is discarded.

## Configuration
- `IMMDEC_TARGET_EN` defined:
  - One XLEN adder computes pc + imm at decode.
  - The result is stored in O and K and drives `out_target`.
- Not defined: no adder, no `out_target` port, and no target storage.

## Structure
- Package `imm_decode_pkg`:
  - Opcode localparams.
  - `imm_fmt_e` enum (3-bit, values as listed above).
  - Entry struct typedef parameterised by XLEN through a function or macro.
- Sub-module `imm_format_decode`:
  - Combinational: instruction to {fmt, imm}.
  - Instantiated once on the input side.
  - Unit-testable on its own.
- Top level contains only the O/K registers and the handshake logic.

## Test plan
- XLEN=32, formats, each with `out_ready` held high:
  - 0xFFF00093 (addi −1): fmt I, imm 0xFFFFFFFF.
  - 0xFE112E23 (sw −4): fmt S, imm 0xFFFFFFFC.
  - 0xFE000CE3 (beq −8): fmt B, imm 0xFFFFFFF8.
  - 0x123452B7 (lui): fmt U, imm 0x12345000.
- Shift and target: 0x4030D093 (srai 3) → fmt SH, imm 3. 0x001000EF (jal +2048) at pc 0x1000 → imm 0x800, and with `IMMDEC_TARGET_EN` `out_target` 0x1800.
- Backpressure:
  - Hold `out_ready` = 0 and offer A, B, C back-to-back.
  - A and B are accepted; `in_ready` falls after B; C is held.
  - Release `out_ready`: outputs appear in order A, B, C with no gaps.
- Flush: with O and K both full, assert `flush` together with `in_valid`. Next cycle `out_valid` = 0, `in_ready` = 1, and the offered word is not emitted.
- XLEN=64:
  - 0x03F09093 (slli 63): imm 63.
  - 0x0010809B (addiw +1): imm 1.
  - 0x0000007F (unknown opcode): fmt NONE, imm 0.
- Reset: assert `rst_n` low mid-burst with both entries held. `out_valid` drops asynchronously; after release the first new input appears 1 cycle after acceptance.
